sram_bus_arbiter: RTL

//  Shares one SRAM-like bus (req/addr_ok/data_ok) between the fetch port (inst) and the

---
 rtl/sram_bus_arbiter.sv | 130 +++++++++++++
 1 files changed

// File: rtl/sram_bus_arbiter.sv
// rtl/sram_bus_arbiter.sv - shares one SRAM-like bus between the fetch (inst) and load/store (data) ports
// Fixed-priority address-phase grant with hold-until-accept and an in-order ID FIFO for response routing.
module sram_bus_arbiter #(
  parameter int MAX_OUTSTANDING = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        inst_req,
  input  logic        inst_wr,
  input  logic [1:0]  inst_size,
  input  logic [31:0] inst_addr,
  input  logic [3:0]  inst_wstrb,
  input  logic [31:0] inst_wdata,
  output logic        inst_addr_ok,
  output logic        inst_data_ok,
  output logic [31:0] inst_rdata,
  input  logic        data_req,
  input  logic        data_wr,
  input  logic [1:0]  data_size,
  input  logic [31:0] data_addr,
  input  logic [3:0]  data_wstrb,
  input  logic [31:0] data_wdata,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  output logic [31:0] data_rdata,
  output logic        sram_req,
  output logic        sram_wr,
  output logic [1:0]  sram_size,
  output logic [31:0] sram_addr,
  output logic [3:0]  sram_wstrb,
  output logic [31:0] sram_wdata,
  input  logic        sram_addr_ok,
  input  logic        sram_data_ok,
  input  logic [31:0] sram_rdata
);

  localparam int PW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int CW = $clog2(MAX_OUTSTANDING + 1);

  typedef enum logic [1:0] {IDLE, HOLD_I, HOLD_D} state_t;

  state_t                     state;
  logic [CW-1:0]              count;
  logic [PW-1:0]              rd_ptr;
  logic [PW-1:0]              wr_ptr;
  logic [MAX_OUTSTANDING-1:0] id_fifo;

  logic full;
  logic sel_data;
  logic want;
  logic accept;
  logic pop;
  logic head_id;

  assign full = (count == CW'(MAX_OUTSTANDING));

  // A held grant ignores the full flag: holds only start from non-full and count cannot grow meanwhile.
  always_comb begin
    sel_data = 1'b0;
    want     = 1'b0;
    case (state)
      HOLD_I: begin
        sel_data = 1'b0;
        want     = inst_req;
      end
      HOLD_D: begin
        sel_data = 1'b1;
        want     = data_req;
      end
      default: begin
        sel_data = data_req;
        want     = (data_req | inst_req) & ~full;
      end
    endcase
  end

  assign sram_req   = want & ~rst;
  assign sram_wr    = sel_data ? data_wr    : inst_wr;
  assign sram_size  = sel_data ? data_size  : inst_size;
  assign sram_addr  = sel_data ? data_addr  : inst_addr;
  assign sram_wstrb = sel_data ? data_wstrb : inst_wstrb;
  assign sram_wdata = sel_data ? data_wdata : inst_wdata;

  assign accept       = sram_req & sram_addr_ok;
  assign inst_addr_ok = accept & ~sel_data;
  assign data_addr_ok = accept & sel_data;

  // Responses with nothing outstanding (e.g. left over from before reset) are dropped.
  assign pop          = sram_data_ok & (count != '0) & ~rst;
  assign head_id      = id_fifo[rd_ptr];
  assign inst_data_ok = pop & ~head_id;
  assign data_data_ok = pop & head_id;
  assign inst_rdata   = sram_rdata;
  assign data_rdata   = sram_rdata;

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      count  <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (sram_req && !sram_addr_ok)
            state <= sel_data ? HOLD_D : HOLD_I;
        end
        HOLD_I, HOLD_D: begin
          if (accept)
            state <= IDLE;
        end
        default: state <= IDLE;
      endcase

      if (accept) begin
        id_fifo[wr_ptr] <= sel_data;
        wr_ptr          <= wr_ptr + PW'(1);
      end
      if (pop)
        rd_ptr <= rd_ptr + PW'(1);

      case ({accept, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule
